// File: rtl/falafel_mem_responder.sv
// Falafel memory responder: one outstanding word read/write serviced from a local
// array, answered after a fixed latency. Also holds the shared falafel_pkg constants.
package falafel_pkg;
    localparam int unsigned DATA_W = 64;
endpackage

module falafel_mem_responder #(
    parameter int unsigned       DATA_W    = falafel_pkg::DATA_W,
    parameter int unsigned       DEPTH     = 256,
    parameter int unsigned       LATENCY   = 2,
    parameter logic [DATA_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              mem_req_val_i,
    output logic              mem_req_rdy_o,
    input  logic              mem_req_is_write_i,
    input  logic [DATA_W-1:0] mem_req_addr_i,
    input  logic [DATA_W-1:0] mem_req_data_i,
    output logic              mem_rsp_val_o,
    input  logic              mem_rsp_rdy_i,
    output logic [DATA_W-1:0] mem_rsp_data_o,
    output logic              err_o
);

    localparam int unsigned WORD_SIZE = DATA_W / 8;
    localparam int unsigned OFF_W     = $clog2(WORD_SIZE);
    localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W     = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 0) ? (LATENCY - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESPOND
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                rdy_q, rdy_d;
    logic                val_q, val_d;
    logic                err_q, err_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic [DATA_W-1:0]   offset_c;
    logic [DATA_W-1:0]   index_c;
    logic [IDX_W-1:0]    idx_c;
    logic                illegal_c;
    logic                accept_c;
    logic                wr_en_c;

    // Address decode: relative word index plus below-base / misaligned / out-of-range checks
    always_comb begin
        offset_c  = mem_req_addr_i - BASE_ADDR;
        index_c   = offset_c >> OFF_W;
        idx_c     = IDX_W'(index_c);
        illegal_c = (mem_req_addr_i < BASE_ADDR)
                 || ((offset_c & DATA_W'(WORD_SIZE - 1)) != '0)
                 || (index_c >= DATA_W'(DEPTH));
        accept_c  = mem_req_val_i && rdy_q;
        wr_en_c   = accept_c && mem_req_is_write_i && !illegal_c;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if (illegal_c) begin
                        data_d = '0;
                    end else if (mem_req_is_write_i) begin
                        data_d = mem_req_data_i;
                    end else begin
                        data_d = mem_q[idx_c];
                    end
                    err_d   = err_q | illegal_c;
                    cnt_d   = CNT_LOAD;
                    state_d = (LATENCY > 0) ? ST_WAIT : ST_RESPOND;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESPOND;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESPOND: begin
                if (mem_rsp_rdy_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Handshake outputs follow the next state so they are registered yet in phase
        rdy_d = (state_d == ST_IDLE);
        val_d = (state_d == ST_RESPOND);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
            val_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            val_q   <= val_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately not reset so accepted writes survive a reset
    always_ff @(posedge clk_i) begin
        if (wr_en_c) begin
            mem_q[idx_c] <= mem_req_data_i;
        end
    end

    assign mem_req_rdy_o  = rdy_q;
    assign mem_rsp_val_o  = val_q;
    assign mem_rsp_data_o = data_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_falafel_mem_responder.sv
// Bench for falafel_mem_responder: vector table through a LATENCY=2 instance,
// plus backpressure, reset-in-WAIT and a LATENCY=0 instance.
module tb_falafel_mem_responder;

    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_val, req_w, rsp_rdy;
    logic [63:0] req_a, req_d;
    logic        rdy, val, err;
    logic [63:0] data;

    logic        req_val1, req_w1, rsp_rdy1;
    logic [63:0] req_a1, req_d1;
    logic        rdy1, val1, err1;
    logic [63:0] data1;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q [$];

    typedef struct {
        logic        w;
        logic [63:0] a;
        logic [63:0] d;
        logic [63:0] exp;
        logic        err;
    } vec_t;

    vec_t vecs [12];

    always #5 clk = ~clk;

    falafel_mem_responder #(
        .DATA_W(64), .DEPTH(256), .LATENCY(LAT), .BASE_ADDR(64'h0)
    ) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .mem_req_val_i(req_val), .mem_req_rdy_o(rdy),
        .mem_req_is_write_i(req_w), .mem_req_addr_i(req_a), .mem_req_data_i(req_d),
        .mem_rsp_val_o(val), .mem_rsp_rdy_i(rsp_rdy), .mem_rsp_data_o(data),
        .err_o(err)
    );

    falafel_mem_responder #(
        .DATA_W(64), .DEPTH(256), .LATENCY(0), .BASE_ADDR(64'h0)
    ) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .mem_req_val_i(req_val1), .mem_req_rdy_o(rdy1),
        .mem_req_is_write_i(req_w1), .mem_req_addr_i(req_a1), .mem_req_data_i(req_d1),
        .mem_rsp_val_o(val1), .mem_rsp_rdy_i(rsp_rdy1), .mem_rsp_data_o(data1),
        .err_o(err1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One transaction on the LATENCY=2 instance; hold>0 stalls the response that many cycles
    task automatic do_req(input logic w, input logic [63:0] a, input logic [63:0] d,
                          input logic [63:0] exp, input logic exp_err, input int hold);
        int k;
        logic [63:0] e;
        @(negedge clk);
        req_w = w; req_a = a; req_d = d; req_val = 1'b1;
        rsp_rdy = (hold == 0);
        k = 0;
        while (!rdy && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!rdy) begin
            check("accept_timeout", 64'(rdy), 64'd1);
            req_val = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back(exp);
        @(negedge clk);
        req_val = 1'b0;
        check("wait_rdy", 64'(rdy), 64'd0);
        k = 1;
        while (!val && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("latency", 64'(k), 64'(LAT + 1));
        if (!val) begin
            void'(exp_q.pop_front());
            return;
        end
        e = exp_q.pop_front();
        check("rsp_data", data, e);
        check("err", 64'(err), 64'(exp_err));
        for (int i = 0; i < hold; i++) begin
            check("bp_val", 64'(val), 64'd1);
            check("bp_data", data, e);
            check("bp_rdy", 64'(rdy), 64'd0);
            req_val = 1'b1; req_w = 1'b1; req_d = 64'hBAD0;
            @(negedge clk);
        end
        req_val = 1'b0;
        rsp_rdy = 1'b1;
        @(negedge clk);
        check("post_val", 64'(val), 64'd0);
        check("post_rdy", 64'(rdy), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 64'h10,  64'hDEAD_BEEF, 64'hDEAD_BEEF, 1'b0};
        vecs[1]  = '{1'b0, 64'h10,  64'h0,         64'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 64'h80,  64'h40,        64'h40,        1'b0};
        vecs[3]  = '{1'b1, 64'h88,  64'h100,       64'h100,       1'b0};
        vecs[4]  = '{1'b0, 64'h80,  64'h0,         64'h40,        1'b0};
        vecs[5]  = '{1'b0, 64'h88,  64'h0,         64'h100,       1'b0};
        vecs[6]  = '{1'b1, 64'h7F8, 64'h1234,      64'h1234,      1'b0};
        vecs[7]  = '{1'b0, 64'h7F8, 64'h0,         64'h1234,      1'b0};
        vecs[8]  = '{1'b0, 64'h0C,  64'h0,         64'h0,         1'b1};
        vecs[9]  = '{1'b0, 64'h800, 64'h0,         64'h0,         1'b1};
        vecs[10] = '{1'b1, 64'h0C,  64'h55,        64'h0,         1'b1};
        vecs[11] = '{1'b0, 64'h10,  64'h0,         64'hDEAD_BEEF, 1'b1};

        rst_n = 1'b0;
        req_val = 1'b0; req_w = 1'b0; req_a = '0; req_d = '0; rsp_rdy = 1'b1;
        req_val1 = 1'b0; req_w1 = 1'b0; req_a1 = '0; req_d1 = '0; rsp_rdy1 = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_rdy", 64'(rdy), 64'd0);
        check("rst_val", 64'(val), 64'd0);
        check("rst_data", data, 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_rdy_l0", 64'(rdy1), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_rdy", 64'(rdy), 64'd1);
        check("rel_rdy_l0", 64'(rdy1), 64'd1);

        for (int i = 0; i < 12; i++) begin
            do_req(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp, vecs[i].err, 0);
        end

        // Stalled response; a write presented meanwhile must not be taken
        do_req(1'b0, 64'h80, 64'h0, 64'h40, 1'b1, 5);
        do_req(1'b0, 64'h80, 64'h0, 64'h40, 1'b1, 0);

        // LATENCY=0 instance: response next cycle, next acceptance two cycles later
        @(negedge clk);
        req_val1 = 1'b1; req_w1 = 1'b1; req_a1 = 64'h20; req_d1 = 64'h77;
        check("l0_rdy", 64'(rdy1), 64'd1);
        @(negedge clk);
        check("l0_wr_val", 64'(val1), 64'd1);
        check("l0_wr_data", data1, 64'h77);
        check("l0_wr_rdy", 64'(rdy1), 64'd0);
        req_w1 = 1'b0; req_d1 = 64'h0;
        @(negedge clk);
        check("l0_hs_val", 64'(val1), 64'd0);
        check("l0_hs_rdy", 64'(rdy1), 64'd1);
        @(negedge clk);
        check("l0_rd_val", 64'(val1), 64'd1);
        check("l0_rd_data", data1, 64'h77);
        req_val1 = 1'b0;
        @(negedge clk);
        check("l0_idle_val", 64'(val1), 64'd0);

        // Reset while the read is in WAIT
        @(negedge clk);
        req_val = 1'b1; req_w = 1'b0; req_a = 64'h10; rsp_rdy = 1'b1;
        check("rw_rdy", 64'(rdy), 64'd1);
        @(negedge clk);
        req_val = 1'b0;
        check("rw_wait_val", 64'(val), 64'd0);
        check("rw_wait_rdy", 64'(rdy), 64'd0);
        rst_n = 1'b0;
        #1;
        check("rw_rst_val", 64'(val), 64'd0);
        check("rw_rst_err", 64'(err), 64'd0);
        check("rw_rst_rdy", 64'(rdy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rw_rel_rdy", 64'(rdy), 64'd1);
        for (int i = 0; i < 4; i++) begin
            check("rw_no_rsp", 64'(val), 64'd0);
            @(negedge clk);
        end

        do_req(1'b0, 64'h10, 64'h0, 64'hDEAD_BEEF, 1'b0, 0);
        do_req(1'b0, 64'h88, 64'h0, 64'h100, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
